// File: rtl/muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl_if
// Brief    : Request/read bundle between the pipeline and the HI/LO unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_req;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        busy;
    logic        stall;
    logic        done;
    logic        dz;

    modport master (
        output start, op, a, b, rd_req, rd_sel,
        input  rd_data, busy, stall, done, dz
    );

    modport slave (
        input  start, op, a, b, rd_req, rd_sel,
        output rd_data, busy, stall, done, dz
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Brief    : HI/LO multiply/divide unit: fixed-latency MULT, 33-cycle restoring
//            DIV, MTHI/MTLO writes, MFHI/MFLO read with stall.
//            Optional abort port enabled by macro MULDIV_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int unsigned MUL_LAT = 4
) (
    input  wire          clk,
    input  wire          rst_n,
`ifdef MULDIV_ABORT_EN
    input  wire          abort,
`endif
    muldiv_ctrl_if.slave bus
);

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    localparam int         CNT_W        = 5;
    localparam logic [4:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [4:0] DIV_CNT_INIT = 5'd31;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_ITER = 2'd2,
        DIV_FIX  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [31:0]        hi_q,    hi_d;
    logic [31:0]        lo_q,    lo_d;
    logic               done_q,  done_d;
    logic               dz_q,    dz_d;
    // opa holds the multiplicand, or the dividend magnitude that shifts into the quotient
    logic [31:0]        opa_q,   opa_d;
    logic [31:0]        opb_q,   opb_d;
    logic [31:0]        rem_q,   rem_d;
    logic               qneg_q,  qneg_d;
    logic               rneg_q,  rneg_d;
    logic               divz_q,  divz_d;

    logic signed [63:0] w_prod;
    logic [32:0]        w_rem_sh;
    logic [32:0]        w_trial;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic               w_busy;

    assign w_busy   = (state_q != IDLE);
    assign w_prod   = 64'($signed(opa_q)) * 64'($signed(opb_q));
    assign w_rem_sh = {rem_q, opa_q[31]};
    assign w_trial  = w_rem_sh - {1'b0, opb_q};
    // two's-complement negate also maps 0x80000000 to its correct unsigned magnitude
    assign w_a_mag  = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
    assign w_b_mag  = bus.b[31] ? (~bus.b + 32'd1) : bus.b;

    assign bus.busy    = w_busy;
    assign bus.stall   = bus.rd_req & w_busy;
    assign bus.done    = done_q;
    assign bus.dz      = dz_q;
    assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rem_d   = rem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        divz_d  = divz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT: begin
                            opa_d   = bus.a;
                            opb_d   = bus.b;
                            cnt_d   = MUL_CNT_INIT;
                            dz_d    = 1'b0;
                            state_d = MUL_WAIT;
                        end
                        OP_DIV: begin
                            opa_d   = w_a_mag;
                            opb_d   = w_b_mag;
                            rem_d   = 32'd0;
                            qneg_d  = bus.a[31] ^ bus.b[31];
                            rneg_d  = bus.a[31];
                            divz_d  = (bus.b == 32'd0);
                            cnt_d   = DIV_CNT_INIT;
                            dz_d    = 1'b0;
                            // a zero divisor skips iteration and resolves in DIV_FIX
                            state_d = (bus.b == 32'd0) ? DIV_FIX : DIV_ITER;
                        end
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end

            MUL_WAIT: begin
                if (cnt_q == '0) begin
                    hi_d    = w_prod[63:32];
                    lo_d    = w_prod[31:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DIV_ITER: begin
                if (!w_trial[32]) begin
                    rem_d = w_trial[31:0];
                    opa_d = {opa_q[30:0], 1'b1};
                end else begin
                    rem_d = w_rem_sh[31:0];
                    opa_d = {opa_q[30:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = DIV_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DIV_FIX: begin
                if (divz_q) begin
                    hi_d = 32'd0;
                    lo_d = 32'd0;
                    dz_d = 1'b1;
                end else begin
                    lo_d = qneg_q ? (~opa_q + 32'd1) : opa_q;
                    hi_d = rneg_q ? (~rem_q + 32'd1) : rem_q;
                end
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

`ifdef MULDIV_ABORT_EN
        if (abort && w_busy) begin
            state_d = IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dz_d    = dz_q;
            done_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            rem_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            divz_q  <= divz_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, legal range 1..15: multiply latency in cycles.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  operation request, sampled only while busy=0.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
REQ-006 SHALL have port a  input  32  signed operand (dividend, multiplicand, or MTHI/MTLO data).
REQ-007 SHALL have port b  input  32  signed operand (divisor, multiplier).
REQ-008 SHALL have port rd_req  input  1  EX-stage MFHI/MFLO read request.
REQ-009 SHALL have port rd_sel  input  1  read select: 0 LO, 1 HI.
REQ-010 SHALL have port rd_data  output  32  selected HI/LO register value.
REQ-011 SHALL have port busy  output  1  MULT/DIV in progress.
REQ-012 SHALL have port stall  output  1  pipeline stall, combinational: rd_req AND busy.
REQ-013 SHALL have port done  output  1  one-cycle pulse after HI/LO are updated by MULT/DIV.
REQ-014 SHALL have port dz  output  1  sticky divide-by-zero flag; cleared by the next accepted MULT/DIV.

Function
REQ-015 SHALL implement FSM states IDLE, MUL_WAIT, DIV_ITER and DIV_FIX; busy=1 in every state except IDLE.
REQ-016 SHALL, in IDLE with start=1 and op=MULT, latch a and b and enter MUL_WAIT with a cycle counter loaded to MUL_LAT-1.
REQ-017 SHALL, in MUL_WAIT, write the signed 64-bit product to {HI,LO} and return to IDLE at the edge where the counter reaches 0, so that busy is high for exactly MUL_LAT cycles.
REQ-018 SHALL, in IDLE with start=1, op=DIV and b!=0, latch operand magnitudes and signs and enter DIV_ITER.
REQ-019 SHALL, in DIV_ITER, perform one radix-2 restoring step per cycle for 32 cycles, then enter DIV_FIX.
REQ-020 SHALL, in DIV_FIX, apply sign correction, write LO=quotient (truncated toward zero) and HI=remainder (sign of dividend), and return to IDLE; total DIV busy time is 33 cycles.
REQ-021 SHALL, for DIV with b=0, spend one busy cycle, write HI=0 and LO=0, and set dz=1.
REQ-022 SHALL, for DIV of 0x80000000 by 0xFFFFFFFF, produce LO=0x80000000 and HI=0.
REQ-023 SHALL, in IDLE with start=1 and op=MTHI or MTLO, write a to HI or LO at that edge without asserting busy or done.
REQ-024 SHALL ignore start while busy=1: no operand latch, and no effect on HI, LO or the FSM.
REQ-025 SHALL assert done for exactly the one cycle following the edge that wrote HI/LO from MULT/DIV.
REQ-026 SHALL drive rd_data combinationally from the HI/LO registers; the value is valid whenever stall=0.
REQ-027 SHALL, when rd_req=1 and busy=0 in the cycle done=1, return the new result on rd_data.
REQ-028 SHALL leave HI/LO unchanged on any cycle in which no write occurs.

Reset
REQ-029 SHALL, on rst_n=0 at any time (including mid-operation), immediately force the FSM to IDLE and clear HI, LO, the counter, busy, done and dz to 0.
REQ-030 SHALL require no clock edge for reset to take effect; operation resumes on the first rising edge after rst_n=1.

Configuration
REQ-031 SHALL, with macro MULDIV_ABORT_EN defined, add port abort  input  1: when abort=1 while busy=1, the next edge returns the FSM to IDLE, leaves HI/LO unchanged, and does not assert done.
REQ-032 SHALL, without MULDIV_ABORT_EN, have no abort port, and every accepted MULT/DIV SHALL run to completion.

Verification
REQ-033 SHALL cover: MULT a=-3, b=7, MUL_LAT=4 -> busy high for 4 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, done pulses once.
REQ-034 SHALL cover: DIV a=-7, b=2 -> busy for 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF, dz=0.
REQ-035 SHALL cover: DIV a=5, b=0 -> busy for 1 cycle, then HI=0, LO=0, dz=1; a following MULT clears dz.
REQ-036 SHALL cover: rd_req=1, rd_sel=0 during DIV 100/7 -> stall held high until busy falls, then rd_data=14 in the done cycle.
REQ-037 SHALL cover: MTLO a=0x1234 while idle -> LO=0x1234 next cycle with busy=0; start during DIV is ignored.
REQ-038 SHALL cover: rst_n pulsed low at DIV_ITER cycle 10 -> busy=0, HI=LO=0 immediately, with no done pulse.
